// File: rtl/lv_owt_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : lv_owt_tx_arb
// Description : Fixed-priority arbiter (0 > 1 > 2) that shares one OWT
//               transmitter among three requesters (fsm watchdog, wdg timer,
//               spi forward). A grant latches the requester's address/data,
//               raises o_owt_tx_req and waits for i_owt_rx_ack. Completion
//               pulses o_ack[src] for one cycle, followed by a one-cycle DONE
//               gap before the next arbitration.
//
//               Optional feature macro: LV_OWT_ARB_TMO_EN
//                 defined   -> 16-bit ack-timeout counter; a frame with no
//                              ack after TMO_CYC cycles ends with o_tmo_err
//                              and o_ack[src] qualified by o_err=1.
//                 undefined -> WAIT_ACK waits indefinitely; o_err and
//                              o_tmo_err are tied low.
//
// Ports       : i_clk, i_rst_n      clock, asynchronous active-low reset
//               i_owt_com_en        channel enable (requests ignored when 0,
//                                   aborts a frame in flight when it falls)
//               i_req[2:0]          level requests
//               i_addrN / i_dataN   per-requester frame payload
//               o_ack[2:0], o_err   one-cycle completion pulse + error flag
//               o_owt_tx_req        level request to the OWT transmitter
//               o_owt_tx_addr/data  latched payload of the current grant
//               o_owt_tx_src        index of the granted requester
//               i_owt_rx_ack        transfer-complete pulse from OWT receiver
//               o_tmo_err           one-cycle timeout pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module lv_owt_tx_arb #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_owt_com_en,
  input  logic [2:0]        i_req,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  output logic [2:0]        o_ack,
  output logic              o_err,
  output logic              o_owt_tx_req,
  output logic [ADDR_W-1:0] o_owt_tx_addr,
  output logic [DATA_W-1:0] o_owt_tx_data,
  output logic [1:0]        o_owt_tx_src,
  input  logic              i_owt_rx_ack,
  output logic              o_tmo_err
);

  // Elaboration-time range check on the timeout length.
  if (TMO_CYC < 2 || TMO_CYC > 65535) begin : g_tmo_cyc_bad
    $error("lv_owt_tx_arb: TMO_CYC out of range 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Goes high on the first edge after reset release; gating arbitration with
  // it pushes the earliest possible grant to the second edge after release.
  logic                armed;

  logic                grant;
  logic                tx_req_nxt;
  logic [2:0]          ack_nxt;
  logic [1:0]          src_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                err_nxt;
  logic                tmo_nxt;

`ifdef LV_OWT_ARB_TMO_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0]         tmo_cnt;
  logic                tmo_hit;
  logic                err_q;
  logic                tmo_q;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    tx_req_nxt = o_owt_tx_req;
    ack_nxt    = 3'b000;
    err_nxt    = 1'b0;
    tmo_nxt    = 1'b0;
    src_nxt    = o_owt_tx_src;
    addr_nxt   = o_owt_tx_addr;
    data_nxt   = o_owt_tx_data;

    case (state)
      IDLE: begin
        if (armed && i_owt_com_en && (i_req != 3'b000)) begin
          grant      = 1'b1;
          tx_req_nxt = 1'b1;
          state_nxt  = WAIT_ACK;
          // Lowest set bit wins.
          if (i_req[0]) begin
            src_nxt  = 2'd0;
            addr_nxt = i_addr0;
            data_nxt = i_data0;
          end else if (i_req[1]) begin
            src_nxt  = 2'd1;
            addr_nxt = i_addr1;
            data_nxt = i_data1;
          end else begin
            src_nxt  = 2'd2;
            addr_nxt = i_addr2;
            data_nxt = i_data2;
          end
        end
      end

      WAIT_ACK: begin
        // Channel disable takes precedence: the frame is silently dropped
        // and the requester, still holding i_req, retries later.
        if (!i_owt_com_en) begin
          tx_req_nxt = 1'b0;
          state_nxt  = IDLE;
        end else if (i_owt_rx_ack) begin
          // An ack on the timeout cycle still wins.
          tx_req_nxt = 1'b0;
          ack_nxt    = 3'(3'b001 << o_owt_tx_src);
          state_nxt  = DONE;
        end
`ifdef LV_OWT_ARB_TMO_EN
        else if (tmo_hit) begin
          tx_req_nxt = 1'b0;
          ack_nxt    = 3'(3'b001 << o_owt_tx_src);
          err_nxt    = 1'b1;
          tmo_nxt    = 1'b1;
          state_nxt  = DONE;
        end
`endif
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        tx_req_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      o_owt_tx_req  <= 1'b0;
      o_ack         <= 3'b000;
      o_owt_tx_src  <= 2'd0;
      o_owt_tx_addr <= '0;
      o_owt_tx_data <= '0;
    end else begin
      state         <= state_nxt;
      armed         <= 1'b1;
      o_owt_tx_req  <= tx_req_nxt;
      o_ack         <= ack_nxt;
      o_owt_tx_src  <= src_nxt;
      o_owt_tx_addr <= addr_nxt;
      o_owt_tx_data <= data_nxt;
    end
  end

`ifdef LV_OWT_ARB_TMO_EN
  // Timeout counter: cleared on grant, counts every WAIT_ACK cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= 16'd0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      err_q <= err_nxt;
      tmo_q <= tmo_nxt;
      if (grant) begin
        tmo_cnt <= 16'd0;
      end else if (state == WAIT_ACK) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

  assign o_err     = err_q;
  assign o_tmo_err = tmo_q;
`else
  // Without the timeout feature the error qualifiers are constant; the
  // next-value terms are always zero and are consumed here only so every
  // net has a reader.
  logic unused_tmo;
  assign unused_tmo = err_nxt | tmo_nxt | grant;
  assign o_err      = 1'b0;
  assign o_tmo_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lv_owt_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lv_owt_tx_arb
// Description : Directed self-checking bench for lv_owt_tx_arb. Inputs are
//               driven and outputs sampled 1 time unit after each rising
//               clock edge. Timeout scenarios run only when
//               LV_OWT_ARB_TMO_EN is defined; otherwise the bench checks that
//               WAIT_ACK waits indefinitely without error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lv_owt_tx_arb;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int TMO_CYC = 8;

  logic              clk;
  logic              rst_n;
  logic              com_en;
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [DATA_W-1:0] data0, data1, data2;
  logic [2:0]        ack;
  logic              err;
  logic              tx_req;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        tx_src;
  logic              rx_ack;
  logic              tmo_err;

  int checks = 0;
  int errors = 0;

  lv_owt_tx_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_owt_com_en (com_en),
    .i_req        (req),
    .i_addr0      (addr0),
    .i_addr1      (addr1),
    .i_addr2      (addr2),
    .i_data0      (data0),
    .i_data1      (data1),
    .i_data2      (data2),
    .o_ack        (ack),
    .o_err        (err),
    .o_owt_tx_req (tx_req),
    .o_owt_tx_addr(tx_addr),
    .o_owt_tx_data(tx_data),
    .o_owt_tx_src (tx_src),
    .i_owt_rx_ack (rx_ack),
    .o_tmo_err    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {tx_req, src, addr, data}
  function automatic logic [17:0] txv();
    return {tx_req, tx_src, tx_addr, tx_data};
  endfunction

  // {ack, err, tmo_err}
  function automatic logic [4:0] ackv();
    return {ack, err, tmo_err};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; com_en = 1'b0; req = 3'b000; rx_ack = 1'b0;
    addr0 = 7'h21; addr1 = 7'h12; addr2 = 7'h33;
    data0 = 8'h5A; data1 = 8'hA5; data2 = 8'hC3;
    step(); step();
    checks++;
    if ({txv(), ackv()} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", {txv(), ackv()});
    end
    // Request already pending at release: no grant on the first edge.
    com_en = 1'b1; req = 3'b001;
    rst_n = 1'b1;
    step();
    checks++;
    if (tx_req !== 1'b0) begin
      errors++; $display("FAIL reset_first_edge_grant: got tx_req=%b exp 0", tx_req);
    end
    step();
    checks++;
    if (txv() !== {1'b1, 2'd0, 7'h21, 8'h5A}) begin
      errors++; $display("FAIL reset_second_edge_grant: got %h exp %h", txv(), {1'b1, 2'd0, 7'h21, 8'h5A});
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    checks++;
    if ({tx_req, ackv()} !== {1'b0, 3'b001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_frame_ack: got %b exp 000100", {tx_req, ackv()});
    end
    step();
  endtask

  task automatic test_single();
    // Ack in IDLE is ignored.
    step();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    checks++;
    if ({tx_req, ack} !== 4'b0000) begin
      errors++; $display("FAIL idle_ack_ignored: got %b exp 0000", {tx_req, ack});
    end
    req = 3'b110;
    step();
    checks++;
    if (txv() !== {1'b1, 2'd1, 7'h12, 8'hA5}) begin
      errors++; $display("FAIL single_grant: got %h exp %h", txv(), {1'b1, 2'd1, 7'h12, 8'hA5});
    end
    // Payload stays frozen while inputs move during the frame.
    addr1 = 7'h7F; data1 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({txv(), ack} !== {1'b1, 2'd1, 7'h12, 8'hA5, 3'b000}) begin
        errors++; $display("FAIL single_hold cyc%0d: got %h exp %h", i, {txv(), ack}, {1'b1, 2'd1, 7'h12, 8'hA5, 3'b000});
      end
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    checks++;
    if ({tx_req, ackv()} !== {1'b0, 3'b010, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_ack: got %b exp 001000", {tx_req, ackv()});
    end
    step();
    checks++;
    if ({txv(), ack} !== {1'b0, 2'd1, 7'h12, 8'hA5, 3'b000}) begin
      errors++; $display("FAIL single_ack_one_cycle: got %h exp %h", {txv(), ack}, {1'b0, 2'd1, 7'h12, 8'hA5, 3'b000});
    end
    addr1 = 7'h12; data1 = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [2:0]        exp_ack [3];
    logic [ADDR_W-1:0] exp_addr[3];
    logic [DATA_W-1:0] exp_data[3];
    exp_ack[0]  = 3'b001;  exp_ack[1]  = 3'b010;  exp_ack[2]  = 3'b100;
    exp_addr[0] = 7'h21;   exp_addr[1] = 7'h12;   exp_addr[2] = 7'h33;
    exp_data[0] = 8'h5A;   exp_data[1] = 8'hA5;   exp_data[2] = 8'hC3;
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (txv() !== {1'b1, 2'(k), exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL b2b_grant%0d: got %h exp %h", k, txv(), {1'b1, 2'(k), exp_addr[k], exp_data[k]});
      end
      step();
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
      req[k] = 1'b0;
      checks++;
      if ({tx_req, ack} !== {1'b0, exp_ack[k]}) begin
        errors++; $display("FAIL b2b_ack%0d: got %b exp %b", k, {tx_req, ack}, {1'b0, exp_ack[k]});
      end
      // DONE cycle: no grant even though lower-priority requests are pending.
      step();
      checks++;
      if ({tx_req, ack} !== 4'b0000) begin
        errors++; $display("FAIL b2b_done_gap%0d: got %b exp 0000", k, {tx_req, ack});
      end
    end
    step();
    checks++;
    if (tx_req !== 1'b0) begin
      errors++; $display("FAIL b2b_no_extra_grant: got %b exp 0", tx_req);
    end
  endtask

  task automatic test_no_preempt();
    req = 3'b100;
    step();
    req = 3'b101;   // higher priority arrives mid-frame
    step(); step();
    checks++;
    if ({tx_req, tx_src} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL no_preempt: got %b exp 110", {tx_req, tx_src});
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b001;
    checks++;
    if (ack !== 3'b100) begin
      errors++; $display("FAIL no_preempt_ack: got %b exp 100", ack);
    end
    step(); step();
    checks++;
    if ({tx_req, tx_src} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL held_req_served: got %b exp 100", {tx_req, tx_src});
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    step();
  endtask

  task automatic test_abort();
    req = 3'b001;
    step();                 // grant, WAIT_ACK cycle 1
    step(); step();         // cycles 2, 3
    com_en = 1'b0;
    step();
    checks++;
    if ({tx_req, ackv()} !== 6'b000000) begin
      errors++; $display("FAIL abort_clear: got %b exp 000000", {tx_req, ackv()});
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    checks++;
    if ({tx_req, ack} !== 4'b0000) begin
      errors++; $display("FAIL abort_late_ack: got %b exp 0000", {tx_req, ack});
    end
    step();
    checks++;
    if (ack !== 3'b000) begin
      errors++; $display("FAIL abort_no_ack: got %b exp 000", ack);
    end
    com_en = 1'b1;          // requester still holds req: retry
    step();
    checks++;
    if ({tx_req, tx_src} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL abort_retry: got %b exp 100", {tx_req, tx_src});
    end
  endtask

  task automatic test_reset_mid_frame();
    // Entered with a frame of requester 0 in flight.
    addr0 = 7'h4C; data0 = 8'h96;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({txv(), ackv()} !== 23'd0) begin
      errors++; $display("FAIL reset_async: got %h exp 0", {txv(), ackv()});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({tx_req, ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_no_stale_ack: got %b exp 0000", {tx_req, ack});
    end
    step();
    checks++;
    if (txv() !== {1'b1, 2'd0, 7'h4C, 8'h96}) begin
      errors++; $display("FAIL reset_relatch: got %h exp %h", txv(), {1'b1, 2'd0, 7'h4C, 8'h96});
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    checks++;
    if (ackv() !== {3'b001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_relatch_ack: got %b exp 00100", ackv());
    end
    step();
  endtask

  task automatic test_timeout();
`ifdef LV_OWT_ARB_TMO_EN
    req = 3'b010;
    step();                         // grant edge G
    for (int i = 1; i < TMO_CYC; i++) begin
      step();
      checks++;
      if ({tx_req, ackv()} !== 6'b100000) begin
        errors++; $display("FAIL tmo_wait cyc%0d: got %b exp 100000", i, {tx_req, ackv()});
      end
    end
    step();                         // edge G+TMO_CYC
    req = 3'b000;
    checks++;
    if ({tx_req, ackv()} !== {1'b0, 3'b010, 1'b1, 1'b1}) begin
      errors++; $display("FAIL tmo_fire: got %b exp 001011", {tx_req, ackv()});
    end
    step();
    checks++;
    if (ackv() !== 5'b00000) begin
      errors++; $display("FAIL tmo_one_cycle: got %b exp 00000", ackv());
    end
    // Ack on the timeout cycle wins.
    req = 3'b100;
    step();
    for (int i = 1; i < TMO_CYC; i++) step();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    checks++;
    if ({tx_req, ackv()} !== {1'b0, 3'b100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tmo_ack_wins: got %b exp 010000", {tx_req, ackv()});
    end
    step();
`else
    int seen_err;
    seen_err = 0;
    req = 3'b010;
    step();
    for (int i = 0; i < 4 * TMO_CYC; i++) begin
      step();
      if (tmo_err !== 1'b0 || err !== 1'b0 || ack !== 3'b000 || tx_req !== 1'b1) seen_err++;
    end
    checks++;
    if (seen_err != 0) begin
      errors++; $display("FAIL no_tmo_wait: got %0d bad cycles exp 0", seen_err);
    end
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0; req = 3'b000;
    checks++;
    if ({tx_req, ackv()} !== {1'b0, 3'b010, 1'b0, 1'b0}) begin
      errors++; $display("FAIL no_tmo_ack: got %b exp 001000", {tx_req, ackv()});
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_preempt();
    test_abort();
    test_reset_mid_frame();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
